// File: rtl/modred_arbiter_pkg.sv
// modred_arbiter_pkg
//   Shared definitions for the modular multiply/reduce arbiter:
//   requester count, tag-pipe entry layout, and small helper functions.
//   DATA_SIZE defaults to the codebase-wide DATA_SIZE_ARB value (32).
package modred_arbiter_pkg;

  localparam int NUM_REQ  = 2;
  localparam int REQ_ID_W = 1;

  localparam int DATA_SIZE_DEF = 32;

  // Width of the tag field carried through the tracking pipe.
  localparam int TAG_W_ARB = 8;

  // One tracking-pipe slot: which requester owns the op in this stage and its tag.
  typedef struct packed {
    logic                 valid;
    logic [REQ_ID_W-1:0]  id;
    logic [TAG_W_ARB-1:0] tag;
  } tag_entry_t;

  // The in-flight count never exceeds LATENCY+2, so clog2(LATENCY+3) bits suffice.
  function automatic int inflight_cnt_w(input int latency);
    return $clog2(latency + 3);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/modred_arbiter_tag_pipe.sv
// modred_tag_pipe
//   DEPTH-stage shift register of tag_entry_t with synchronous reset.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset (clears every stage)
//     entry_in    : entry captured into stage 0 each cycle
//     entry_out   : last stage (DEPTH-1)
module modred_tag_pipe
  import modred_arbiter_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  tag_entry_t entry_in,
  output tag_entry_t entry_out
);

  tag_entry_t stage_q [DEPTH];
  tag_entry_t stage_d [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign stage_d[gi] = entry_in;
    end else begin : g_body
      assign stage_d[gi] = stage_q[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign entry_out = stage_q[DEPTH-1];

endmodule

// File: rtl/modred_arbiter.sv
// modred_arbiter
//   Shares one fixed-latency modular multiply/reduce pipeline between two
//   requesters. Round-robin grant, one issue per cycle, requester id/tag
//   tracked alongside the pipeline and the result routed back to its owner.
//   Owns the modulus register; a new modulus is only accepted with the pipe empty.
//   Ports:
//     cfg_valid/cfg_q/cfg_ready         : modulus load handshake
//     req_valid/req_a/req_b/req_tag     : packed per-requester operations
//     req_ready                         : per-requester grant (one-hot or zero)
//     mm_valid/mm_a/mm_b/mm_q/mm_result : shared pipeline interface
//     rsp_valid/rsp_data/rsp_tag        : results, no backpressure
//     busy                              : any operation in flight
//   Optional (macro MODRED_ARB_PERF_EN): perf_issue0, perf_issue1, perf_conflict
//     saturating 32-bit counters, cleared on reset and on modulus load.
module modred_arbiter
  import modred_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int LATENCY   = 6,   // must be >= 1
  parameter int TAG_W     = TAG_W_ARB
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  input  logic [DATA_SIZE-1:0]   cfg_q,
  output logic                   cfg_ready,
  input  logic [1:0]             req_valid,
  input  logic [2*DATA_SIZE-1:0] req_a,
  input  logic [2*DATA_SIZE-1:0] req_b,
  input  logic [2*TAG_W-1:0]     req_tag,
  output logic [1:0]             req_ready,
  output logic                   mm_valid,
  output logic [DATA_SIZE-1:0]   mm_a,
  output logic [DATA_SIZE-1:0]   mm_b,
  output logic [DATA_SIZE-1:0]   mm_q,
  input  logic [DATA_SIZE-1:0]   mm_result,
  output logic [1:0]             rsp_valid,
  output logic [DATA_SIZE-1:0]   rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   busy
`ifdef MODRED_ARB_PERF_EN
  ,
  output logic [31:0]            perf_issue0,
  output logic [31:0]            perf_issue1,
  output logic [31:0]            perf_conflict
`endif
);

  localparam int CNT_W = inflight_cnt_w(LATENCY);

  // Unpacked views of the packed request buses.
  logic [DATA_SIZE-1:0] a_arr   [NUM_REQ];
  logic [DATA_SIZE-1:0] b_arr   [NUM_REQ];
  logic [TAG_W-1:0]     tag_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi]   = req_a[gi*DATA_SIZE +: DATA_SIZE];
    assign b_arr[gi]   = req_b[gi*DATA_SIZE +: DATA_SIZE];
    assign tag_arr[gi] = req_tag[gi*TAG_W +: TAG_W];
  end

  logic                 rr_q, rr_d;
  logic                 q_loaded_q, q_loaded_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] mod_q, mod_d;
  logic                 mm_valid_q, mm_valid_d;
  logic [DATA_SIZE-1:0] mm_a_q, mm_a_d;
  logic [DATA_SIZE-1:0] mm_b_q, mm_b_d;
  logic [1:0]           rsp_valid_q, rsp_valid_d;
  logic [DATA_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;

  logic [1:0]          grant;
  logic                both_valid;
  logic                xfer;
  logic [REQ_ID_W-1:0] xfer_id;
  logic                cfg_accept;
  logic                resp_fire;
  tag_entry_t          pipe_in;
  tag_entry_t          pipe_out;

  // Grant. Any pending cfg_valid blocks issue: either the modulus is loaded
  // this cycle, or the pipe is draining so the load cannot be starved.
  always_comb begin
    both_valid = &req_valid;
    grant      = '0;
    if (q_loaded_q && !cfg_valid) begin
      if (both_valid) begin
        grant[rr_q] = 1'b1;
      end else begin
        grant = req_valid;
      end
    end
    xfer       = |grant;
    xfer_id    = grant[1];
    cfg_accept = cfg_valid && (cnt_q == '0) && !xfer;
  end

  // Entry enters stage 0 on transfer; with LATENCY+1 stages the tail lines up
  // with mm_result, which appears LATENCY cycles after the registered mm_valid.
  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = xfer;
    pipe_in.id    = xfer_id;
    pipe_in.tag   = TAG_W_ARB'(tag_arr[xfer_id]);
  end

  modred_tag_pipe #(
    .DEPTH (LATENCY + 1)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .entry_in  (pipe_in),
    .entry_out (pipe_out)
  );

  assign resp_fire = pipe_out.valid;

  always_comb begin
    rr_d        = rr_q;
    q_loaded_d  = q_loaded_q | cfg_accept;
    mod_d       = mod_q;
    cnt_d       = cnt_q;
    mm_valid_d  = xfer;
    mm_a_d      = mm_a_q;
    mm_b_d      = mm_b_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;

    // Pointer only rotates when it actually arbitrated between two requests.
    if (xfer && both_valid) begin
      rr_d = ~rr_q;
    end
    if (cfg_accept) begin
      mod_d = cfg_q;
    end
    if (xfer) begin
      mm_a_d = a_arr[xfer_id];
      mm_b_d = b_arr[xfer_id];
    end

    unique case ({xfer, resp_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (resp_fire) begin
      rsp_valid_d[pipe_out.id] = 1'b1;
      rsp_data_d               = mm_result;
      rsp_tag_d                = TAG_W'(pipe_out.tag);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q        <= 1'b0;
      q_loaded_q  <= 1'b0;
      cnt_q       <= '0;
      mod_q       <= '0;
      mm_valid_q  <= 1'b0;
      mm_a_q      <= '0;
      mm_b_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      q_loaded_q  <= q_loaded_d;
      cnt_q       <= cnt_d;
      mod_q       <= mod_d;
      mm_valid_q  <= mm_valid_d;
      mm_a_q      <= mm_a_d;
      mm_b_q      <= mm_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign req_ready = grant;
  assign cfg_ready = cfg_accept;
  assign mm_valid  = mm_valid_q;
  assign mm_a      = mm_a_q;
  assign mm_b      = mm_b_q;
  assign mm_q      = mod_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign busy      = (cnt_q != '0);

`ifdef MODRED_ARB_PERF_EN
  logic [31:0] perf_issue0_q, perf_issue0_d;
  logic [31:0] perf_issue1_q, perf_issue1_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  always_comb begin
    perf_issue0_d   = perf_issue0_q;
    perf_issue1_d   = perf_issue1_q;
    perf_conflict_d = perf_conflict_q;
    if (cfg_accept) begin
      perf_issue0_d   = '0;
      perf_issue1_d   = '0;
      perf_conflict_d = '0;
    end else begin
      if (xfer && (xfer_id == 1'b0)) perf_issue0_d = sat_inc32(perf_issue0_q);
      if (xfer && (xfer_id == 1'b1)) perf_issue1_d = sat_inc32(perf_issue1_q);
      // Both asked, exactly one got the slot.
      if (xfer && both_valid) perf_conflict_d = sat_inc32(perf_conflict_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue0_q   <= '0;
      perf_issue1_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_issue0_q   <= perf_issue0_d;
      perf_issue1_q   <= perf_issue1_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_issue0   = perf_issue0_q;
  assign perf_issue1   = perf_issue1_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_modred_arbiter.sv
module tb_modred_arbiter;

  localparam int DW  = 32;
  localparam int LAT = 6;
  localparam int TW  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cfg_valid = 1'b0;
  logic [DW-1:0]   cfg_q = '0;
  logic            cfg_ready;
  logic [1:0]      req_valid = '0;
  logic [2*DW-1:0] req_a = '0;
  logic [2*DW-1:0] req_b = '0;
  logic [2*TW-1:0] req_tag = '0;
  logic [1:0]      req_ready;
  logic            mm_valid;
  logic [DW-1:0]   mm_a, mm_b, mm_q, mm_result;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [TW-1:0]   rsp_tag;
  logic            busy;
`ifdef MODRED_ARB_PERF_EN
  logic [31:0]     perf_issue0, perf_issue1, perf_conflict;
`endif

  modred_arbiter #(.DATA_SIZE(DW), .LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_q(cfg_q), .cfg_ready(cfg_ready),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .req_ready(req_ready),
    .mm_valid(mm_valid), .mm_a(mm_a), .mm_b(mm_b), .mm_q(mm_q), .mm_result(mm_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .busy(busy)
`ifdef MODRED_ARB_PERF_EN
    , .perf_issue0(perf_issue0), .perf_issue1(perf_issue1), .perf_conflict(perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rsp_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mod_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
    logic [63:0] p;
    if (q == 32'd0) return 32'd0;
    p = 64'(a) * 64'(b);
    return 32'(p % 64'(q));
  endfunction

  // Shared pipeline model: LAT-cycle delayed (a*b) mod q, poisoned when idle.
  logic [DW-1:0] mdl_pipe [LAT];
  always @(posedge clk) begin
    mdl_pipe[0] <= mm_valid ? mod_mul(mm_a, mm_b, mm_q) : 32'hDEAD_BEEF;
    for (int k = 1; k < LAT; k++) mdl_pipe[k] <= mdl_pipe[k-1];
  end
  assign mm_result = mdl_pipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out, got no event expected one (cycle %0d)", name, cyc);
  endtask

  // Scoreboard: expected response pushed at each observed transfer.
  typedef struct {
    int          id;
    logic [31:0] data;
    logic [7:0]  tag;
    int          cyc;
  } sb_t;
  sb_t         sb [$];
  logic [31:0] exp_drv [2];
  logic        prev_xfer = 1'b0;
  logic [31:0] prev_a, prev_b;
  int          mon_id;
  sb_t         mon_e;

  always @(negedge clk) begin
    if (reset) begin
      prev_xfer = 1'b0;
    end else begin
      check("mm_valid", {63'd0, mm_valid}, {63'd0, prev_xfer});
      if (prev_xfer) begin
        check("mm_a", mm_a, prev_a);
        check("mm_b", mm_b, prev_b);
      end
      prev_xfer = 1'b0;
      if ((req_ready & ~req_valid) != 2'b00)
        check("grant_subset", req_ready, req_ready & req_valid);
      if (req_ready != 2'b00) begin
        mon_id    = req_ready[1] ? 1 : 0;
        prev_xfer = 1'b1;
        prev_a    = req_a[mon_id*DW +: DW];
        prev_b    = req_b[mon_id*DW +: DW];
        sb.push_back('{mon_id, exp_drv[mon_id], req_tag[mon_id*TW +: TW], cyc});
      end
      if (rsp_valid != 2'b00) begin
        rsp_count++;
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 2'b00);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_valid_id", rsp_valid, (mon_e.id == 1) ? 2'b10 : 2'b01);
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_tag", rsp_tag, mon_e.tag);
          check("rsp_latency", cyc - mon_e.cyc, LAT + 2);
        end
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] tag, input logic [31:0] exp);
    req_a[id*DW +: DW]   = a;
    req_b[id*DW +: DW]   = b;
    req_tag[id*TW +: TW] = tag;
    exp_drv[id]          = exp;
  endtask

  task automatic load_next(input int id, input int n, input logic [31:0] q);
    logic [31:0] a, b;
    a = 32'(1000 + n * 37 + id);
    b = 32'(77 + id);
    set_req(id, a, b, 8'(id * 128 + n), mod_mul(a, b, q));
  endtask

  task automatic issue_one(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] tag, input logic [31:0] exp);
    bit ok;
    ok = 1'b0;
    set_req(id, a, b, tag, exp);
    req_valid[id] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      sample();
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
      drive_edge();
    end
    drive_edge();
    req_valid[id] = 1'b0;
    if (!ok) fail_timeout("issue_grant");
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sample();
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      drive_edge();
    end
    drive_edge();
    if (!ok) fail_timeout("drain");
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  tag;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cnt [2];
    int g;
    int base;
    bit accepted;
    logic [31:0] cur_mod;

    // Expected results below are (a*b) mod 7681.
    vecs[0] = '{0, 32'd3,     32'd5,    8'h11, 32'd15};
    vecs[1] = '{1, 32'd100,   32'd200,  8'h22, 32'd4638};
    vecs[2] = '{0, 32'd7680,  32'd7680, 8'h33, 32'd1};
    vecs[3] = '{1, 32'd0,     32'd1234, 8'h44, 32'd0};
    vecs[4] = '{0, 32'd4000,  32'd2,    8'h55, 32'd319};
    vecs[5] = '{1, 32'd12345, 32'd1,    8'h66, 32'd4664};
    exp_drv[0] = '0;
    exp_drv[1] = '0;
    cur_mod = '0;

    // Reset state.
    repeat (3) drive_edge();
    reset = 1'b0;
    sample();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_mm_valid", mm_valid, 1'b0);
    check("rst_mm_a", mm_a, 32'd0);
    check("rst_mm_q", mm_q, 32'd0);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_tag", rsp_tag, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_cfg_ready", cfg_ready, 1'b0);
`ifdef MODRED_ARB_PERF_EN
    check("rst_perf_issue0", perf_issue0, 32'd0);
`endif

    // No grants before the modulus has ever been loaded.
    drive_edge();
    load_next(0, 0, 32'd7681);
    load_next(1, 0, 32'd7681);
    req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      sample();
      check("noq_req_ready", req_ready, 2'b00);
      drive_edge();
    end
    req_valid = 2'b00;

    // Load modulus 7681: accepted same cycle, visible next cycle.
    cfg_valid = 1'b1;
    cfg_q     = 32'd7681;
    sample();
    check("cfg_ready_idle", cfg_ready, 1'b1);
    drive_edge();
    cfg_valid = 1'b0;
    cur_mod   = 32'd7681;
    sample();
    check("mm_q_7681", mm_q, 32'd7681);
    drive_edge();

    // Table of single operations.
    for (int v = 0; v < 6; v++)
      issue_one(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].tag, vecs[v].exp);
    wait_drain();

    // Contention: both valid for 10 cycles, grants must alternate from 0.
    cnt[0] = 0;
    cnt[1] = 0;
    load_next(0, 0, cur_mod);
    load_next(1, 0, cur_mod);
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      sample();
      check("rr_grant", req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
      g = req_ready[1] ? 1 : 0;
      accepted = (req_ready != 2'b00);
      drive_edge();
      if (accepted) begin
        cnt[g]++;
        load_next(g, cnt[g], cur_mod);
      end
    end
    req_valid = 2'b00;
    check("grants_req0", cnt[0], 5);
    check("grants_req1", cnt[1], 5);

    // Only requester 1 active: granted every cycle.
    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("solo_grant1", req_ready, 2'b10);
      drive_edge();
      cnt[1]++;
      load_next(1, cnt[1], cur_mod);
    end
    // Pointer was not moved by solo grants; requester 0 is next on contention.
    req_valid = 2'b11;
    sample();
    check("rr_after_solo", req_ready, 2'b01);
    drive_edge();
    req_valid = 2'b00;
    cnt[0]++;
    load_next(0, cnt[0], cur_mod);
    wait_drain();

    // Config while busy: three ops in flight, then modulus 12289.
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("busy_issue", req_ready, 2'b01);
      drive_edge();
      cnt[0]++;
      load_next(0, cnt[0], cur_mod);
    end
    load_next(0, cnt[0], 32'd12289);
    cfg_valid = 1'b1;
    cfg_q     = 32'd12289;
    base      = rsp_count;
    accepted  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      check("cfg_hold_grant", req_ready, 2'b00);
      if (cfg_ready) begin
        accepted = 1'b1;
        break;
      end
      drive_edge();
    end
    if (accepted) check("cfg_after_drain", rsp_count - base, 3);
    else fail_timeout("cfg_ready_busy");
    drive_edge();
    cfg_valid = 1'b0;
    cur_mod   = 32'd12289;
    sample();
    check("mm_q_12289", mm_q, 32'd12289);
    check("grant_resume", req_ready, 2'b01);
    drive_edge();
    req_valid = 2'b00;
    wait_drain();

    // Reset with two ops in flight: tracking cleared, late results ignored.
    load_next(1, 40, cur_mod);
    req_valid = 2'b10;
    sample();
    check("rstflight_issue", req_ready, 2'b10);
    drive_edge();
    load_next(1, 41, cur_mod);
    sample();
    check("rstflight_issue", req_ready, 2'b10);
    drive_edge();
    req_valid = 2'b00;
    sample();
    drive_edge();
    reset = 1'b1;
    sb.delete();
    sample();
    drive_edge();
    reset = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      sample();
      check("rstflight_busy", busy, 1'b0);
      check("rstflight_rsp", rsp_valid, 2'b00);
      drive_edge();
    end
    sample();
    check("rstflight_mm_q", mm_q, 32'd0);
`ifdef MODRED_ARB_PERF_EN
    check("perf_issue0_rst", perf_issue0, 32'd0);
    check("perf_issue1_rst", perf_issue1, 32'd0);
    check("perf_conflict_rst", perf_conflict, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modred_arbiter.md
Name: modred_arbiter

Overview:
- Shares one fixed-latency modular multiply/reduce pipeline (multiplier feeding the word-level reduction chain) between two requesters, e.g. two butterfly units.
- Arbitrates issue slots round-robin and launches one operation per cycle into the pipeline.
- Tracks requester ID and tag through a shift register matching the pipeline latency, then routes each result back to its owner.
- Owns the modulus register and allows a modulus change only when the pipeline is empty.

Parameters:
- DATA_SIZE, 32, operand/modulus width (matches the codebase's DATA_SIZE_ARB).
- LATENCY, 6, cycles from mm_valid/operand issue to mm_result valid in the shared pipeline; must be >= 1.
- TAG_W, 8, width of the requester-supplied tag.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cfg_valid  in  1  request to load new modulus
- cfg_q  in  DATA_SIZE  new modulus
- cfg_ready  out  1  high when modulus load is accepted this cycle
- req_valid  in  2  per-requester operation valid
- req_a  in  2*DATA_SIZE  operands A, requester i at [i*DATA_SIZE +: DATA_SIZE]
- req_b  in  2*DATA_SIZE  operands B, same packing
- req_tag  in  2*TAG_W  tags, same packing
- req_ready  out  2  per-requester grant (one-hot or zero)
- mm_valid  out  1  issue strobe to shared pipeline
- mm_a  out  DATA_SIZE  operand A to pipeline
- mm_b  out  DATA_SIZE  operand B to pipeline
- mm_q  out  DATA_SIZE  current modulus to pipeline
- mm_result  in  DATA_SIZE  pipeline result, valid LATENCY cycles after issue
- rsp_valid  out  2  per-requester result strobe
- rsp_data  out  DATA_SIZE  result (shared bus)
- rsp_tag  out  TAG_W  tag of returned result
- busy  out  1  any operation in flight

Behaviour:
- Reset values: req_ready=0, mm_valid=0, mm_a/mm_b=0, q register (mm_q)=0, rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0, cfg_ready=0, RR pointer=0 (requester 0 preferred first), in-flight count=0, ID/tag pipe valids cleared.
- Grant is combinational from req_valid and the RR pointer: if both requests are valid, grant the pointer's requester; if only one, grant it. A grant is blocked while a modulus update is pending (the cfg_valid && !idle cycle, see below) and requires q_loaded=1.
- A transfer occurs on req_valid[i] && req_ready[i]. On a transfer, mm_valid/mm_a/mm_b are registered with 1-cycle latency. The RR pointer moves to the other requester only when both were valid at the transfer.
- Tracking pipe: LATENCY+1 stages of {valid, id, tag}, aligned so that rsp_valid[id], rsp_data<=mm_result and rsp_tag are registered in the cycle mm_result is valid. Total request-to-response latency is LATENCY+2 cycles.
- No backpressure on responses: requesters must accept rsp_valid unconditionally.
- In-flight counter width is clog2(LATENCY+3). It increments on issue, decrements on response, and stays unchanged on simultaneous issue and response. busy = (count != 0).
- Modulus config: cfg_ready = cfg_valid && count==0 && no transfer this cycle. On accept, q <= cfg_q next cycle, and grants are suppressed in that cycle. While cfg_valid is high and the pipe is not idle, grants are suppressed so the pipe drains and config cannot starve.
- q_loaded flag is cleared by reset and set on the first cfg accept. No grants are given before it is set.
- Reset mid-operation clears all in-flight tracking. Results still emerging from the pipeline are ignored (no rsp_valid).

Optional Feature:
- Macro MODRED_ARB_PERF_EN.
- When defined: adds outputs perf_issue0 and perf_issue1 (32-bit, issues per requester) and perf_conflict (32-bit, cycles where both were valid but only one was granted). All are saturating, cleared on reset, and also cleared on a cfg accept.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package holds the requester count constant (2), the tag-pipe entry typedef {valid, id, tag}, and a localparam helper for counter width. DATA_SIZE is taken from the existing global defines.
- One natural sub-module: modred_tag_pipe, a parameterised LATENCY+1-deep shift register of tag-pipe entries with synchronous reset.

Test Plan:
- Config then single op: reset, cfg_q=7681 -> cfg_ready the same cycle, mm_q=7681 next cycle. Requester 0 sends a=3, b=5, tag=0x11 -> mm_valid one cycle after the transfer. Bench model returns 15 at LATENCY=6 -> rsp_valid=2'b01, rsp_data=15, rsp_tag=0x11 exactly 8 cycles after the transfer.
- Contention: both requesters valid continuously for 10 cycles -> grants alternate 0,1,0,1…, each requester gets 5 grants, and responses return in issue order with correct ids and tags.
- Single active requester: only requester 1 valid for 4 cycles -> granted every cycle, back-to-back mm_valid, and the RR pointer does not strand it.
- Config while busy: issue 3 ops, then assert cfg_valid with cfg_q=12289 -> no new grants, cfg_ready only after the 3rd response (count=0), mm_q=12289 afterwards, and grants resume the cycle after.
- Before config: req_valid=2'b11 after reset with no cfg -> req_ready stays 0 for 20 cycles.
- Reset mid-flight: issue 2 ops, assert reset on cycle 3 -> busy=0 and no rsp_valid for the next LATENCY+2 cycles. With MODRED_ARB_PERF_EN defined, the perf counters read 0.
